// File: rtl/bd_deserializer.sv
// Reassembles leaf-coded multi-chunk words from the serialized downstream channel into full BD words.
// Optional build macro BD_DESER_CODE_CHECK_EN: abandon a partial word when a later chunk carries a different code.
module bd_deserializer #(
   parameter int         Ncode      = 8,
   parameter int         Ndata_in   = 24,
   parameter int         NBDpayload = 64,
   parameter int         NLEAF      = 8,
   parameter logic [1:0] CHUNKS_M1 [NLEAF] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1}
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ser_in_v,
   input  logic [Ncode-1:0]      ser_in_code,
   input  logic [Ndata_in-1:0]   ser_in_payload,
   output logic                  ser_in_a,
   output logic                  dec_out_v,
   output logic [Ncode-1:0]      dec_out_leaf_code,
   output logic [NBDpayload-1:0] dec_out_payload,
   input  logic                  dec_out_a,
   output logic                  err_invalid_code,
   output logic                  err_code_mismatch
);

   typedef enum logic {S_IDLE, S_COLLECT} state_t;

   localparam logic [Ncode:0] LP_NLEAF = (Ncode + 1)'(NLEAF);

   // Chunk count minus one for a code; invalid codes never reach a lookup that matters.
   function automatic logic [1:0] m1_of(input logic [Ncode-1:0] code);
      logic [1:0] m1;
      m1 = 2'd0;
      for (int i = 0; i < NLEAF; i++) begin
         if (code == Ncode'(i)) m1 = CHUNKS_M1[i];
      end
      return m1;
   endfunction

   // Chunk k lands at k*Ndata_in; anything above the top payload bit falls off.
   function automatic logic [NBDpayload-1:0] place(input logic [Ndata_in-1:0] d, input logic [1:0] k);
      logic [NBDpayload-1:0] w;
      w = NBDpayload'(d);
      return w << (int'(k) * Ndata_in);
   endfunction

   state_t                r_state;
   logic [1:0]            r_idx;
   logic [Ncode-1:0]      r_asm_code;
   logic [NBDpayload-1:0] r_asm_payload;
   logic                  r_out_v;
   logic [Ncode-1:0]      r_out_code;
   logic [NBDpayload-1:0] r_out_payload;
   logic                  r_err_inv;

   state_t                w_state_nxt;
   logic [1:0]            w_idx_nxt;
   logic [Ncode-1:0]      w_asm_code_nxt;
   logic [NBDpayload-1:0] w_asm_payload_nxt;
   logic                  w_out_v_nxt;
   logic [Ncode-1:0]      w_out_code_nxt;
   logic [NBDpayload-1:0] w_out_payload_nxt;
   logic                  w_err_inv_nxt;

   logic                  w_code_ok;
   logic [1:0]            w_in_m1;
   logic [1:0]            w_asm_m1;
   logic                  w_mismatch;
   logic                  w_first;
   logic                  w_completes;
   logic                  w_out_free;
   logic                  w_xfer;
   logic [NBDpayload-1:0] w_merged;

   assign w_code_ok = ({1'b0, ser_in_code} < LP_NLEAF);
   assign w_in_m1   = m1_of(ser_in_code);
   assign w_asm_m1  = m1_of(r_asm_code);

`ifdef BD_DESER_CODE_CHECK_EN
   assign w_mismatch = (r_state == S_COLLECT) && (ser_in_code != r_asm_code);
`else
   assign w_mismatch = 1'b0;
`endif

   // A mismatching chunk restarts assembly, so it is judged exactly like a chunk arriving in IDLE.
   assign w_first     = (r_state == S_IDLE) || w_mismatch;
   assign w_completes = w_first ? (w_code_ok && (w_in_m1 == 2'd0)) : (r_idx == w_asm_m1);
   assign w_out_free  = !r_out_v || dec_out_a;
   assign ser_in_a    = !w_completes || w_out_free;
   assign w_xfer      = ser_in_v && ser_in_a;
   assign w_merged    = w_first ? place(ser_in_payload, 2'd0)
                                : (r_asm_payload | place(ser_in_payload, r_idx));

   // NOTE: every signal written here gets its hold value first, so no path leaves one unassigned (no latch).
   always_comb begin
      w_state_nxt       = r_state;
      w_idx_nxt         = r_idx;
      w_asm_code_nxt    = r_asm_code;
      w_asm_payload_nxt = r_asm_payload;
      w_out_v_nxt       = r_out_v && !dec_out_a;
      w_out_code_nxt    = r_out_code;
      w_out_payload_nxt = r_out_payload;
      w_err_inv_nxt     = 1'b0;

      if (w_xfer) begin
         if (w_completes) begin
            w_out_v_nxt       = 1'b1;
            w_out_code_nxt    = w_first ? ser_in_code : r_asm_code;
            w_out_payload_nxt = w_merged;
            w_state_nxt       = S_IDLE;
            w_idx_nxt         = 2'd0;
            w_asm_payload_nxt = '0;
         end else if (w_first) begin
            if (!w_code_ok) begin
               w_err_inv_nxt     = 1'b1;
               w_state_nxt       = S_IDLE;
               w_idx_nxt         = 2'd0;
               w_asm_payload_nxt = '0;
            end else begin
               w_asm_code_nxt    = ser_in_code;
               w_asm_payload_nxt = w_merged;
               w_idx_nxt         = 2'd1;
               w_state_nxt       = S_COLLECT;
            end
         end else begin
            w_asm_payload_nxt = w_merged;
            w_idx_nxt         = r_idx + 2'd1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_idx         <= 2'd0;
         r_asm_code    <= '0;
         r_asm_payload <= '0;
         r_out_v       <= 1'b0;
         r_out_code    <= '0;
         r_out_payload <= '0;
         r_err_inv     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_idx         <= w_idx_nxt;
         r_asm_code    <= w_asm_code_nxt;
         r_asm_payload <= w_asm_payload_nxt;
         r_out_v       <= w_out_v_nxt;
         r_out_code    <= w_out_code_nxt;
         r_out_payload <= w_out_payload_nxt;
         r_err_inv     <= w_err_inv_nxt;
      end
   end

`ifdef BD_DESER_CODE_CHECK_EN
   logic r_err_mm;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_err_mm <= 1'b0;
      else       r_err_mm <= w_xfer && w_mismatch;
   end

   assign err_code_mismatch = r_err_mm;
`else
   assign err_code_mismatch = 1'b0;
`endif

   assign dec_out_v         = r_out_v;
   assign dec_out_leaf_code = r_out_code;
   assign dec_out_payload   = r_out_payload;
   assign err_invalid_code  = r_err_inv;

endmodule

// File: tb/tb_bd_deserializer.sv
// Self-checking bench for bd_deserializer: directed vector table, reset corner case, and a random
// run against a queue-based word-assembly model.
module tb_bd_deserializer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ser_in_v = 1'b0;
   logic [7:0]  ser_in_code = '0;
   logic [23:0] ser_in_payload = '0;
   logic        ser_in_a;
   logic        dec_out_v;
   logic [7:0]  dec_out_leaf_code;
   logic [63:0] dec_out_payload;
   logic        dec_out_a = 1'b0;
   logic        err_invalid_code;
   logic        err_code_mismatch;

   int n_checks = 0;
   int n_fail   = 0;

   bd_deserializer dut (
      .clk               (clk),
      .reset             (reset),
      .ser_in_v          (ser_in_v),
      .ser_in_code       (ser_in_code),
      .ser_in_payload    (ser_in_payload),
      .ser_in_a          (ser_in_a),
      .dec_out_v         (dec_out_v),
      .dec_out_leaf_code (dec_out_leaf_code),
      .dec_out_payload   (dec_out_payload),
      .dec_out_a         (dec_out_a),
      .err_invalid_code  (err_invalid_code),
      .err_code_mismatch (err_code_mismatch)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input bit ev, input logic [7:0] ec,
                             input logic [63:0] ep, input bit einv, input bit emm);
      check({tag, ".v"}, 64'(dec_out_v), 64'(ev));
      if (ev) begin
         check({tag, ".code"}, 64'(dec_out_leaf_code), 64'(ec));
         check({tag, ".payload"}, dec_out_payload, ep);
      end
      check({tag, ".err_inv"}, 64'(err_invalid_code), 64'(einv));
      check({tag, ".err_mm"}, 64'(err_code_mismatch), 64'(emm));
   endtask

   // One cycle: drive at the falling edge, capture ser_in_a, then settle just past the rising edge.
   task automatic drive_cycle(input bit v, input logic [7:0] code, input logic [23:0] pay,
                              input bit oa, output bit a_seen);
      @(negedge clk);
      ser_in_v       = v;
      ser_in_code    = code;
      ser_in_payload = pay;
      dec_out_a      = oa;
      #1 a_seen = ser_in_a;
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   int          tbl_n [8] = '{1, 1, 2, 2, 3, 1, 1, 2};
   logic [23:0] m_q [$];
   logic [7:0]  m_code;
   bit          m_out_v;
   logic [7:0]  m_out_code;
   logic [63:0] m_out_pay;
   bit          m_inv, m_mm;

   function automatic logic [63:0] join_chunks();
      logic [63:0] p = 64'd0;
      foreach (m_q[k]) p += 64'(m_q[k]) * (64'd1 << (24 * k));
      return p;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_code = '0; m_out_v = 0; m_out_code = '0; m_out_pay = '0; m_inv = 0; m_mm = 0;
   endtask

   task automatic model_step(input bit v, input logic [7:0] code, input logic [23:0] pay,
                             input bit oa, output bit exp_a);
      bit starting, mism, valid, complete;
      mism = 0;
`ifdef BD_DESER_CODE_CHECK_EN
      mism = (m_q.size() > 0) && (code != m_code);
`endif
      starting = (m_q.size() == 0) || mism;
      valid    = (code < 8);
      if (starting) complete = valid ? (tbl_n[code[2:0]] == 1) : 1'b0;
      else          complete = (m_q.size() + 1 == tbl_n[m_code[2:0]]);
      exp_a = !complete || !m_out_v || oa;
      m_inv = 0;
      m_mm  = 0;
      if (m_out_v && oa) m_out_v = 0;
      if (v && exp_a) begin
         if (starting) begin
            if (mism) m_mm = 1;
            m_q.delete();
            if (!valid) m_inv = 1;
            else begin
               m_code = code;
               m_q.push_back(pay);
            end
         end else begin
            m_q.push_back(pay);
         end
         if (complete) begin
            m_out_v    = 1;
            m_out_code = m_code;
            m_out_pay  = join_chunks();
            m_q.delete();
         end
      end
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      bit          v;
      logic [7:0]  code;
      logic [23:0] pay;
      bit          oa;
      bit          exp_a;
      bit          exp_v;
      logic [7:0]  exp_code;
      logic [63:0] exp_pay;
      bit          exp_inv;
      bit          exp_mm;
   } vec_t;

   vec_t vecs [15];

   initial begin
      bit a_seen, exp_a;

      //          v  code   pay          oa a  v  code  payload                  inv mm
      vecs[0]  = '{1, 8'd0, 24'hABCDEF, 1, 1, 1, 8'd0, 64'h0000_0000_00AB_CDEF, 0, 0};
      vecs[1]  = '{1, 8'd4, 24'h111111, 1, 1, 0, 8'd0, 64'h0,                   0, 0};
      vecs[2]  = '{1, 8'd4, 24'h222222, 1, 1, 0, 8'd0, 64'h0,                   0, 0};
      vecs[3]  = '{1, 8'd4, 24'hFF3333, 1, 1, 1, 8'd4, 64'h3333_2222_2211_1111, 0, 0};
      vecs[4]  = '{1, 8'd0, 24'h00AAAA, 1, 1, 1, 8'd0, 64'h0000_0000_0000_AAAA, 0, 0};
      vecs[5]  = '{1, 8'd2, 24'h0B0B0B, 0, 1, 1, 8'd0, 64'h0000_0000_0000_AAAA, 0, 0};
      vecs[6]  = '{1, 8'd2, 24'h0C0C0C, 0, 0, 1, 8'd0, 64'h0000_0000_0000_AAAA, 0, 0};
      vecs[7]  = '{1, 8'd2, 24'h0C0C0C, 1, 1, 1, 8'd2, 64'h0000_0C0C_0C0B_0B0B, 0, 0};
      vecs[8]  = '{0, 8'd0, 24'h000000, 1, 1, 0, 8'd0, 64'h0,                   0, 0};
      vecs[9]  = '{1, 8'd9, 24'h123456, 1, 1, 0, 8'd0, 64'h0,                   1, 0};
      vecs[10] = '{0, 8'd0, 24'h000000, 1, 1, 0, 8'd0, 64'h0,                   0, 0};
      vecs[11] = '{1, 8'd1, 24'h000777, 1, 1, 1, 8'd1, 64'h0000_0000_0000_0777, 0, 0};
      vecs[12] = '{1, 8'd2, 24'h000001, 1, 1, 0, 8'd0, 64'h0,                   0, 0};
`ifdef BD_DESER_CODE_CHECK_EN
      vecs[13] = '{1, 8'd0, 24'h000005, 1, 1, 1, 8'd0, 64'h0000_0000_0000_0005, 0, 1};
`else
      vecs[13] = '{1, 8'd0, 24'h000005, 1, 1, 1, 8'd2, 64'h0000_0000_0500_0001, 0, 0};
`endif
      vecs[14] = '{0, 8'd0, 24'h000000, 1, 1, 0, 8'd0, 64'h0,                   0, 0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset.ser_in_a", 64'(ser_in_a), 64'd1);
      check_outs("reset", 0, 8'd0, 64'd0, 0, 0);
      check("reset.code", 64'(dec_out_leaf_code), 64'd0);
      check("reset.payload", dec_out_payload, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         drive_cycle(vecs[i].v, vecs[i].code, vecs[i].pay, vecs[i].oa, a_seen);
         check($sformatf("vec%0d.ser_in_a", i), 64'(a_seen), 64'(vecs[i].exp_a));
         check_outs($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_code, vecs[i].exp_pay,
                    vecs[i].exp_inv, vecs[i].exp_mm);
      end

      // Reset in the middle of a word, with an undelivered word still in the output register
      drive_cycle(1, 8'd0, 24'h5A5A5A, 0, a_seen);
      check("rst_mid.held_v", 64'(dec_out_v), 64'd1);
      drive_cycle(1, 8'd4, 24'h000001, 0, a_seen);
      drive_cycle(1, 8'd4, 24'h000002, 0, a_seen);
      check("rst_mid.chunk1_a", 64'(a_seen), 64'd1);
      @(negedge clk);
      ser_in_v = 1'b0;
      reset    = 1'b1;
      #2;
      check("rst_mid.v", 64'(dec_out_v), 64'd0);
      check("rst_mid.ser_in_a", 64'(ser_in_a), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      drive_cycle(1, 8'd0, 24'h000042, 1, a_seen);
      check_outs("rst_mid.after", 1, 8'd0, 64'h42, 0, 0);
      drive_cycle(0, 8'd0, 24'h0, 1, a_seen);
      check_outs("rst_mid.idle", 0, 8'd0, 64'd0, 0, 0);

      // Random traffic against the model, from a fresh reset
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         bit          v, oa;
         logic [7:0]  code;
         logic [23:0] pay;
         v    = ($urandom_range(0, 9) < 7);
         oa   = ($urandom_range(0, 9) < 6);
         code = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
         pay  = 24'($urandom);
         @(negedge clk);
         ser_in_v       = v;
         ser_in_code    = code;
         ser_in_payload = pay;
         dec_out_a      = oa;
         #1;
         model_step(v, code, pay, oa, exp_a);
         check("rnd.ser_in_a", 64'(ser_in_a), 64'(exp_a));
         @(posedge clk);
         #1;
         check_outs("rnd", m_out_v, m_out_code, m_out_pay, m_inv, m_mm);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
